wb_ram_slave: RTL and testbench

Wishbone B3 slave front end for the on-chip single-port RAM in the peripheral subsystem. It sits directly upstream of the RAM macro: it decodes Wishbone cycles into RAM word address, byte enables, write strobe and write data, and generates the acknowledge. The RAM has one cycle of registered read latency. Incrementing read bursts (CTI=010) run at one beat per cycle by prefetching the next address; all other accesses use the classic two-cycle handshake.

---
 rtl/wb_ram_slave.sv | 105 ++++++++++
 tb/tb_wb_ram_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave front end for a single-port RAM with one cycle of registered read latency.
// Classic accesses take two cycles; incrementing read bursts run one beat per cycle via address prefetch.
module wb_ram_slave #(
    parameter int ADR_WIDTH = 12,
    parameter bit BURST_EN  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 ram_we_o,
    output logic [ADR_WIDTH-1:0] ram_adr_o,
    output logic [3:0]           ram_be_o,
    output logic [31:0]          ram_dat_o,
    input  logic [31:0]          ram_dat_i
);

    localparam logic [2:0] CTI_INCR = 3'b010;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q;
    logic                 ack_q;
    logic [ADR_WIDTH-1:0] nxt_adr_q;

    logic                 req;
    logic                 rd_incr;
    logic [ADR_WIDTH-1:0] wb_word;
    logic                 unused_adr_bits;

    // Wrapping bursts only advance the low 2/3/4 bits; upper address bits stay put.
    function automatic logic [ADR_WIDTH-1:0] incr(input logic [ADR_WIDTH-1:0] a,
                                                  input logic [1:0]           bte);
        logic [ADR_WIDTH-1:0] mask;
        logic [ADR_WIDTH-1:0] sum;
        sum = a + ADR_WIDTH'(1);
        case (bte)
            2'b01:   mask = ADR_WIDTH'(4'h3);
            2'b10:   mask = ADR_WIDTH'(4'h7);
            2'b11:   mask = ADR_WIDTH'(4'hF);
            default: mask = '1;
        endcase
        return (a & ~mask) | (sum & mask);
    endfunction

    assign req             = wb_cyc_i & wb_stb_i;
    assign rd_incr         = req & ~wb_we_i & (wb_cti_i == CTI_INCR);
    assign wb_word         = wb_adr_i[ADR_WIDTH+1:2];
    assign unused_adr_bits = ^{wb_adr_i[31:ADR_WIDTH+2], wb_adr_i[1:0]};

    assign ram_adr_o = (state_q == BURST && !wb_we_i) ? nxt_adr_q : wb_word;
    assign ram_we_o  = req & wb_we_i & ack_q & ~rst_i;
    assign ram_be_o  = wb_sel_i;
    assign ram_dat_o = wb_dat_i;
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = (ack_q & ~wb_we_i & ~rst_i) ? ram_dat_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            nxt_adr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A strobe still held during the ack cycle belongs to the beat just acked.
                    if (ack_q) begin
                        ack_q <= 1'b0;
                    end else if (req) begin
                        ack_q <= 1'b1;
                        if (BURST_EN && rd_incr) begin
                            state_q   <= BURST;
                            nxt_adr_q <= incr(ram_adr_o, wb_bte_i);
                        end
                    end
                end
                BURST: begin
                    if (rd_incr) begin
                        ack_q     <= 1'b1;
                        nxt_adr_q <= incr(nxt_adr_q, wb_bte_i);
                    end else begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: reset, classic write/read, linear/wrap bursts, abort, write bursts.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] wb_dat;
    logic        wb_ack;
    logic        ram_we;
    logic [11:0] ram_adr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdat;
    logic [31:0] ram_rdat = 32'h0;

    logic [31:0] mem [0:4095];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_ram_slave #(.ADR_WIDTH(12), .BURST_EN(1'b1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (wdat),
        .wb_cti_i  (cti),
        .wb_bte_i  (bte),
        .wb_dat_o  (wb_dat),
        .wb_ack_o  (wb_ack),
        .ram_we_o  (ram_we),
        .ram_adr_o (ram_adr),
        .ram_be_o  (ram_be),
        .ram_dat_o (ram_wdat),
        .ram_dat_i (ram_rdat)
    );

    // RAM macro: registered read of the old contents, byte-enabled write.
    always @(posedge clk) begin
        ram_rdat <= mem[ram_adr];
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_adr][8*b +: 8] = ram_wdat[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                           input logic [3:0] sl, input logic [31:0] d, input logic [2:0] ct,
                           input logic [1:0] bt);
        cyc = c; stb = s; we = w; adr = a; sel = sl; wdat = d; cti = ct; bte = bt;
    endtask

    task automatic idle();
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle at its falling edge, then advance to just after the next rising edge.
    task automatic beat(input string tag, input logic exp_ack, input logic exp_we,
                        input logic [31:0] exp_dat);
        @(negedge clk);
        chk({tag, ".ack"}, 32'(wb_ack), 32'(exp_ack));
        chk({tag, ".we"},  32'(ram_we), 32'(exp_we));
        chk({tag, ".dat"}, wb_dat, exp_dat);
        step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[4] = 32'h11223344;

        // Reset held with a write request pending
        rst = 1'b1;
        set_bus(1'b1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678, 3'b000, 2'b00);
        step();
        for (int i = 0; i < 3; i++) beat("rst_hold", 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        beat("rst_rel0", 1'b0, 1'b0, 32'h0);
        beat("rst_rel1", 1'b1, 1'b1, 32'h0);
        idle();
        beat("rst_rel2", 1'b0, 1'b0, 32'h0);

        // Classic write with partial byte lanes, then read back
        set_bus(1'b1, 1'b1, 1'b1, 32'h10, 4'b0101, 32'hDEADBEEF, 3'b000, 2'b00);
        beat("cw0", 1'b0, 1'b0, 32'h0);
        chk("cw1.adr", 32'(ram_adr), 32'h4);
        chk("cw1.be", 32'(ram_be), 32'h5);
        chk("cw1.wdat", ram_wdat, 32'hDEADBEEF);
        beat("cw1", 1'b1, 1'b1, 32'h0);
        idle();
        beat("cw2", 1'b0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("cr0", 1'b0, 1'b0, 32'h0);
        beat("cr1", 1'b1, 1'b0, 32'h11AD33EF);
        idle();
        beat("cr2", 1'b0, 1'b0, 32'h0);

        // Word written during the reset-release cycle
        set_bus(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("rr0", 1'b0, 1'b0, 32'h0);
        beat("rr1", 1'b1, 1'b0, 32'h12345678);
        idle();
        beat("rr2", 1'b0, 1'b0, 32'h0);

        // Linear 4-beat burst from word 0x20
        set_bus(1'b1, 1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("lb0", 1'b0, 1'b0, 32'h0);
        beat("lb1", 1'b1, 1'b0, 32'hC0DE0020);
        set_bus(1'b1, 1'b1, 1'b0, 32'h84, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("lb2", 1'b1, 1'b0, 32'hC0DE0021);
        set_bus(1'b1, 1'b1, 1'b0, 32'h88, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("lb3", 1'b1, 1'b0, 32'hC0DE0022);
        set_bus(1'b1, 1'b1, 1'b0, 32'h8C, 4'hF, 32'h0, 3'b111, 2'b00);
        beat("lb4", 1'b1, 1'b0, 32'hC0DE0023);
        idle();
        beat("lb5", 1'b0, 1'b0, 32'h0);

        // Wrap-4 burst from word 6: 6,7,4,5
        set_bus(1'b1, 1'b1, 1'b0, 32'h18, 4'hF, 32'h0, 3'b010, 2'b01);
        beat("w4_0", 1'b0, 1'b0, 32'h0);
        beat("w4_1", 1'b1, 1'b0, 32'hC0DE0006);
        set_bus(1'b1, 1'b1, 1'b0, 32'h1C, 4'hF, 32'h0, 3'b010, 2'b01);
        beat("w4_2", 1'b1, 1'b0, 32'hC0DE0007);
        set_bus(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 3'b010, 2'b01);
        beat("w4_3", 1'b1, 1'b0, 32'h11AD33EF);
        set_bus(1'b1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0, 3'b111, 2'b01);
        beat("w4_4", 1'b1, 1'b0, 32'hC0DE0005);
        idle();
        beat("w4_5", 1'b0, 1'b0, 32'h0);

        // Linear burst across the top of the address space
        set_bus(1'b1, 1'b1, 1'b0, 32'h3FFC, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("top0", 1'b0, 1'b0, 32'h0);
        beat("top1", 1'b1, 1'b0, 32'hC0DE0FFF);
        set_bus(1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 3'b111, 2'b00);
        beat("top2", 1'b1, 1'b0, 32'hC0DE0000);
        idle();
        beat("top3", 1'b0, 1'b0, 32'h0);

        // Abort an 8-beat burst by dropping stb after the second beat
        set_bus(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("ab0", 1'b0, 1'b0, 32'h0);
        beat("ab1", 1'b1, 1'b0, 32'hC0DE0040);
        set_bus(1'b1, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("ab2", 1'b1, 1'b0, 32'hC0DE0041);
        set_bus(1'b1, 1'b0, 1'b0, 32'h108, 4'hF, 32'h0, 3'b010, 2'b00);
        @(negedge clk);
        chk("ab3.we", 32'(ram_we), 32'h0);
        step();
        beat("ab4", 1'b0, 1'b0, 32'h0);
        beat("ab5", 1'b0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 1'b0, 32'h108, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("ab_cr0", 1'b0, 1'b0, 32'h0);
        beat("ab_cr1", 1'b1, 1'b0, 32'hC0DE0042);
        idle();
        beat("ab_cr2", 1'b0, 1'b0, 32'h0);

        // Incrementing write burst falls back to classic handshakes
        set_bus(1'b1, 1'b1, 1'b1, 32'hC0, 4'hF, 32'hAAAA0001, 3'b010, 2'b00);
        beat("wb0", 1'b0, 1'b0, 32'h0);
        chk("wb1.adr", 32'(ram_adr), 32'h30);
        beat("wb1", 1'b1, 1'b1, 32'h0);
        set_bus(1'b1, 1'b1, 1'b1, 32'hC4, 4'hF, 32'hAAAA0002, 3'b111, 2'b00);
        beat("wb2", 1'b0, 1'b0, 32'h0);
        chk("wb3.adr", 32'(ram_adr), 32'h31);
        beat("wb3", 1'b1, 1'b1, 32'h0);
        idle();
        beat("wb4", 1'b0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 1'b0, 32'hC0, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("wbr0", 1'b0, 1'b0, 32'h0);
        beat("wbr1", 1'b1, 1'b0, 32'hAAAA0001);
        idle();
        beat("wbr2", 1'b0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 1'b0, 32'hC4, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("wbr3", 1'b0, 1'b0, 32'h0);
        beat("wbr4", 1'b1, 1'b0, 32'hAAAA0002);
        idle();
        beat("wbr5", 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a read burst
        set_bus(1'b1, 1'b1, 1'b0, 32'h140, 4'hF, 32'h0, 3'b010, 2'b00);
        beat("mr0", 1'b0, 1'b0, 32'h0);
        beat("mr1", 1'b1, 1'b0, 32'hC0DE0050);
        set_bus(1'b1, 1'b1, 1'b0, 32'h144, 4'hF, 32'h0, 3'b010, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        chk("mr2.dat", wb_dat, 32'h0);
        chk("mr2.we", 32'(ram_we), 32'h0);
        step();
        rst = 1'b0;
        idle();
        beat("mr3", 1'b0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 1'b0, 32'h144, 4'hF, 32'h0, 3'b000, 2'b00);
        beat("mr4", 1'b0, 1'b0, 32'h0);
        beat("mr5", 1'b1, 1'b0, 32'hC0DE0051);
        idle();
        beat("mr6", 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
